// File: rtl/pulse_seq_detector.sv
// Detects SEQ_LEN consecutive rising edges on one of N_CH lines.
// An optional gap timeout bounds the spacing between counted edges.
module pulse_seq_detector #(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned SEQ_LEN = 3,
  parameter int unsigned TIMEOUT = 0,
  localparam int unsigned CH_W   = (N_CH > 2) ? $clog2(N_CH) : 1,
  localparam int unsigned CNT_W  = $clog2(SEQ_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [N_CH-1:0]   pulse_in,
  output logic [N_CH-1:0]   seq_hit,
  output logic              collision,
  output logic [CH_W-1:0]   cur_ch,
  output logic [CNT_W-1:0]  cur_cnt
);

  localparam int unsigned GAP_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GapMax  = GAP_W'(TIMEOUT);
  localparam logic [GAP_W-1:0] GapLast = GAP_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SeqLen  = CNT_W'(SEQ_LEN);

  logic [N_CH-1:0]  r_prev;
  logic [N_CH-1:0]  r_seq_hit, w_seq_hit_d;
  logic             r_collision, w_collision_d;
  logic [CH_W-1:0]  r_cur_ch, w_cur_ch_d;
  logic [CNT_W-1:0] r_cur_cnt, w_cur_cnt_d;
  logic [GAP_W-1:0] r_gap, w_gap_d;

  logic [N_CH-1:0]  w_rise;
  logic             w_any, w_multi, w_cnt_nz;
  logic [CH_W-1:0]  w_rise_ch;
  logic [CNT_W-1:0] w_next_cnt;

  assign w_rise     = pulse_in & ~r_prev;
  assign w_any      = |w_rise;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign w_multi    = |(w_rise & (w_rise - N_CH'(1)));
  assign w_cnt_nz   = (r_cur_cnt != '0);
  assign w_next_cnt = r_cur_cnt + CNT_W'(1);

  always_comb begin
    w_rise_ch = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_rise[i]) w_rise_ch = CH_W'(i);
    end
  end

  always_comb begin
    w_seq_hit_d   = '0;
    w_collision_d = 1'b0;
    w_cur_ch_d    = r_cur_ch;
    w_cur_cnt_d   = r_cur_cnt;
    w_gap_d       = r_gap;
    if (enable) begin
      if (!w_any) begin
        if (w_cnt_nz && (TIMEOUT != 0) && (r_gap == GapLast)) begin
          w_cur_cnt_d = '0;
          w_gap_d     = '0;
        end else if (w_cnt_nz && (r_gap != GapMax)) begin
          w_gap_d = r_gap + GAP_W'(1);
        end
      end else if (w_multi) begin
        w_cur_cnt_d   = '0;
        w_gap_d       = '0;
        w_collision_d = 1'b1;
      end else if (w_cnt_nz && (w_rise_ch == r_cur_ch)) begin
        w_gap_d = '0;
        if (w_next_cnt == SeqLen) begin
          w_seq_hit_d = w_rise;
          w_cur_cnt_d = '0;
        end else begin
          w_cur_cnt_d = w_next_cnt;
        end
      end else begin
        w_cur_ch_d = w_rise_ch;
        w_gap_d    = '0;
        if (SEQ_LEN == 1) begin
          w_seq_hit_d = w_rise;
          w_cur_cnt_d = '0;
        end else begin
          w_cur_cnt_d = CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev      <= '1;
      r_seq_hit   <= '0;
      r_collision <= 1'b0;
      r_cur_ch    <= '0;
      r_cur_cnt   <= '0;
      r_gap       <= '0;
    end else begin
      r_prev      <= pulse_in;
      r_seq_hit   <= w_seq_hit_d;
      r_collision <= w_collision_d;
      r_cur_ch    <= w_cur_ch_d;
      r_cur_cnt   <= w_cur_cnt_d;
      r_gap       <= w_gap_d;
    end
  end

  assign seq_hit   = r_seq_hit;
  assign collision = r_collision;
  assign cur_ch    = r_cur_ch;
  assign cur_cnt   = r_cur_cnt;

endmodule

// File: tb/tb_pulse_seq_detector.sv
// Directed bench: default config, a TIMEOUT=4 config and a 4-channel SEQ_LEN=1 config.
module tb_pulse_seq_detector;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en0;
  logic [1:0] p0, p1;
  logic [3:0] p2;

  logic [1:0] hit0, hit1;
  logic [3:0] hit2;
  logic       col0, col1, col2;
  logic       ch0, ch1;
  logic [1:0] ch2;
  logic [1:0] cnt0, cnt1;
  logic       cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_seq_detector #(.N_CH(2), .SEQ_LEN(3), .TIMEOUT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(en0), .pulse_in(p0),
    .seq_hit(hit0), .collision(col0), .cur_ch(ch0), .cur_cnt(cnt0)
  );

  pulse_seq_detector #(.N_CH(2), .SEQ_LEN(3), .TIMEOUT(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(1'b1), .pulse_in(p1),
    .seq_hit(hit1), .collision(col1), .cur_ch(ch1), .cur_cnt(cnt1)
  );

  pulse_seq_detector #(.N_CH(4), .SEQ_LEN(1), .TIMEOUT(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(1'b1), .pulse_in(p2),
    .seq_hit(hit2), .collision(col2), .cur_ch(ch2), .cur_cnt(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step0(input string tag, input logic en, input logic [1:0] pin,
                       input logic [1:0] e_hit, input logic e_col, input logic e_ch,
                       input logic [1:0] e_cnt);
    en0 = en;
    p0  = pin;
    tick();
    check({tag, ".hit"}, 32'(hit0), 32'(e_hit));
    check({tag, ".col"}, 32'(col0), 32'(e_col));
    check({tag, ".ch"},  32'(ch0),  32'(e_ch));
    check({tag, ".cnt"}, 32'(cnt0), 32'(e_cnt));
  endtask

  task automatic step1(input string tag, input logic [1:0] pin, input logic [1:0] e_hit,
                       input logic [1:0] e_cnt);
    p1 = pin;
    tick();
    check({tag, ".hit"}, 32'(hit1), 32'(e_hit));
    check({tag, ".cnt"}, 32'(cnt1), 32'(e_cnt));
  endtask

  task automatic step2(input string tag, input logic [3:0] pin, input logic [3:0] e_hit,
                       input logic [1:0] e_ch);
    p2 = pin;
    tick();
    check({tag, ".hit"}, 32'(hit2), 32'(e_hit));
    check({tag, ".ch"},  32'(ch2),  32'(e_ch));
    check({tag, ".cnt"}, 32'(cnt2), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    en0     = 1'b1;
    p0      = 2'b11;
    p1      = 2'b00;
    p2      = 4'b0000;
    #1;
    check("rst.hit", 32'(hit0), 32'd0);
    check("rst.col", 32'(col0), 32'd0);
    check("rst.ch",  32'(ch0),  32'd0);
    check("rst.cnt", 32'(cnt0), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;

    // Lines already high at reset release give no edge.
    step0("rel",   1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 2'd0);
    step0("rel2",  1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0);

    // Three edges on channel 0.
    step0("t1.c1", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0);
    step0("t1.c2", 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'd1);
    step0("t1.c3", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'd1);
    step0("t1.c4", 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'd2);
    step0("t1.c5", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'd2);
    step0("t1.c6", 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 2'd0);
    step0("t1.c7", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0);

    // Channel switch restarts the run.
    step0("t2.a1", 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'd1);
    step0("t2.z1", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'd1);
    step0("t2.a2", 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'd2);
    step0("t2.z2", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'd2);
    step0("t2.b1", 1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 2'd1);
    step0("t2.z3", 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 2'd1);
    step0("t2.b2", 1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 2'd2);
    step0("t2.z4", 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 2'd2);
    step0("t2.b3", 1'b1, 2'b10, 2'b10, 1'b0, 1'b1, 2'd0);
    step0("t2.z5", 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 2'd0);

    // Collision clears the count but keeps cur_ch.
    step0("t3.a1", 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'd1);
    step0("t3.z1", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'd1);
    step0("t3.ab", 1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 2'd0);
    step0("t3.z2", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0);
    step0("t3.a2", 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'd1);
    step0("t3.z3", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'd1);
    step0("t3.a3", 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'd2);
    step0("t3.z4", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'd2);
    step0("t3.a4", 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 2'd0);
    step0("t3.z5", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0);

    // Back-to-back runs: six edges give two hits.
    for (int k = 0; k < 6; k++) begin
      step0("t4.e", 1'b1, 2'b01, (k % 3 == 2) ? 2'b01 : 2'b00, 1'b0, 1'b0,
            2'((k + 1) % 3));
      step0("t4.z", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'((k + 1) % 3));
    end

    // Edge while disabled is lost; state frozen.
    step0("t5.a1", 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'd1);
    step0("t5.z1", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'd1);
    step0("t5.d1", 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'd1);
    step0("t5.d2", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'd1);
    step0("t5.z2", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'd1);
    step0("t5.a2", 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'd2);
    step0("t5.z3", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'd2);
    step0("t5.a3", 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 2'd0);
    step0("t5.z4", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0);

    // TIMEOUT=4: edges at 2 and 6 count, expiry in cycle 10, edge at 11 restarts.
    step1("to.c0",  2'b00, 2'b00, 2'd0);
    step1("to.c1",  2'b00, 2'b00, 2'd0);
    step1("to.c2",  2'b01, 2'b00, 2'd1);
    step1("to.c3",  2'b00, 2'b00, 2'd1);
    step1("to.c4",  2'b00, 2'b00, 2'd1);
    step1("to.c5",  2'b00, 2'b00, 2'd1);
    step1("to.c6",  2'b01, 2'b00, 2'd2);
    step1("to.c7",  2'b00, 2'b00, 2'd2);
    step1("to.c8",  2'b00, 2'b00, 2'd2);
    step1("to.c9",  2'b00, 2'b00, 2'd2);
    step1("to.c10", 2'b00, 2'b00, 2'd0);
    step1("to.c11", 2'b01, 2'b00, 2'd1);
    step1("to.c12", 2'b00, 2'b00, 2'd1);

    // N_CH=4, SEQ_LEN=1: single edge on channel 3 hits immediately.
    for (int k = 0; k < 5; k++) step2("s1.idle", 4'b0000, 4'b0000, 2'd0);
    step2("s1.hit", 4'b1000, 4'b1000, 2'd3);
    check("s1.col", 32'(col2), 32'd0);

    // Asynchronous reset drops outputs without a clock edge.
    reset_n = 1'b0;
    #1;
    check("ar.hit", 32'(hit2), 32'd0);
    check("ar.col", 32'(col2), 32'd0);
    check("ar.ch",  32'(ch2),  32'd0);
    check("ar.cnt", 32'(cnt2), 32'd0);
    check("ar.cnt1", 32'(cnt1), 32'd0);
    tick();
    reset_n = 1'b1;
    step2("ar.post", 4'b1000, 4'b0000, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
